vga_timing_gen: RTL and testbench

- Upstream raster timing stage for the background and sprite renderers.
- Generates the 1024x768@60 (XGA) pixel/line counters, hsync/vsync, video_active and the pix_x/pix_y coordinates consumed by the background generator.
- Also provides line/frame strobes and a free-running frame counter, so downstream animation can run synchronously instead of clocking off vsync edges.
- Counters advance only on cycles where pix_en=1, so the block runs from a faster system clock.

---
 rtl/vga_timing_gen.sv | 122 ++++++++++++
 tb/tb_vga_timing_gen.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: XGA raster timing, with pixel/line counters, syncs, active window, strobes and a frame counter.
// Latency: 1 enabled cycle. All outputs are registered and describe (h_cnt, v_cnt) as it was before the increment.
// Backpressure: none. pix_en=0 freezes the counters and every output, including the strobes.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 1024,
  parameter int H_FP      = 24,
  parameter int H_SYNC    = 136,
  parameter int H_BP      = 160,
  parameter int V_ACTIVE  = 768,
  parameter int V_FP      = 3,
  parameter int V_SYNC    = 6,
  parameter int V_BP      = 29,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        video_active,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Decode boundaries, pre-sized to the 11-bit counter width
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);

  // Coordinates must fit 10 bits, totals must fit the 11-bit counters
  localparam bit PARAMS_OK = (H_ACTIVE <= 1024) && (V_ACTIVE <= 1024) &&
                             (H_TOTAL <= 2047) && (V_TOTAL <= 2047) &&
                             (H_FP >= 1) && (H_SYNC >= 1) && (H_BP >= 1) &&
                             (V_FP >= 1) && (V_SYNC >= 1) && (V_BP >= 1);

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic [9:0]  pix_x_q, pix_x_d;
  logic [9:0]  pix_y_q, pix_y_d;
  logic        active_q, active_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Raster position advance: h wraps at end of line, v steps on h wrap and wraps at end of frame
  always_comb begin
    h_cnt_d = h_cnt_q + 11'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = 11'd0;
      v_cnt_d = (v_cnt_q == V_LAST) ? 11'd0 : v_cnt_q + 11'd1;
    end
  end

  // Output decode of the current position; frame_cnt counts the frame_start already on the output
  always_comb begin
    active_d      = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
    pix_x_d       = active_d ? h_cnt_q[9:0] : 10'd0;
    pix_y_d       = active_d ? v_cnt_q[9:0] : 10'd0;
    hsync_d       = ((h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d       = ((v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END)) ? VSYNC_POL : ~VSYNC_POL;
    line_start_d  = (h_cnt_q == 11'd0);
    frame_start_d = (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);
    frame_cnt_d   = frame_start_q ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end

  // State and output registers; reset wins over pix_en and idles both syncs
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q       <= 11'd0;
      v_cnt_q       <= 11'd0;
      pix_x_q       <= 10'd0;
      pix_y_q       <= 10'd0;
      active_q      <= 1'b0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= 16'd0;
    end else if (pix_en) begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      active_q      <= active_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  // Simulation-only guard against an illegal timing parameter set
  always @(posedge clk) begin
    assert (PARAMS_OK) else $error("vga_timing_gen: illegal timing parameters");
  end

  assign pix_x        = pix_x_q;
  assign pix_y        = pix_y_q;
  assign video_active = active_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign line_start   = line_start_q;
  assign frame_start  = frame_start_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: bench for vga_timing_gen (XGA instance plus two small-geometry instances of opposite sync polarity).
// Latency: expected outputs derive from the count of enabled cycles since reset.
// Backpressure: pix_en is driven in fixed and random patterns.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        act;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
  } obs_t;

  // Small geometry: 25 x 14 raster, frame = 350 enabled cycles
  localparam int S_HA = 16, S_HFP = 2, S_HS = 3, S_HBP = 4;
  localparam int S_VA = 8,  S_VFP = 1, S_VS = 2, S_VBP = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_en = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] b_x, b_y, s_x, s_y, p_x, p_y;
  logic b_act, b_hs, b_vs, b_ls, b_fs;
  logic s_act, s_hs, s_vs, s_ls, s_fs;
  logic p_act, p_hs, p_vs, p_ls, p_fs;
  logic [15:0] b_fc, s_fc, p_fc;
  obs_t ob_b, ob_s, ob_p;

  assign ob_b = {b_x, b_y, b_act, b_hs, b_vs, b_ls, b_fs, b_fc};
  assign ob_s = {s_x, s_y, s_act, s_hs, s_vs, s_ls, s_fs, s_fc};
  assign ob_p = {p_x, p_y, p_act, p_hs, p_vs, p_ls, p_fs, p_fc};

  vga_timing_gen dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .pix_x(b_x), .pix_y(b_y),
    .video_active(b_act), .hsync(b_hs), .vsync(b_vs), .line_start(b_ls),
    .frame_start(b_fs), .frame_cnt(b_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut_s (
    .clk(clk), .rst(rst), .pix_en(pix_en), .pix_x(s_x), .pix_y(s_y),
    .video_active(s_act), .hsync(s_hs), .vsync(s_vs), .line_start(s_ls),
    .frame_start(s_fs), .frame_cnt(s_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dut_p (
    .clk(clk), .rst(rst), .pix_en(pix_en), .pix_x(p_x), .pix_y(p_y),
    .video_active(p_act), .hsync(p_hs), .vsync(p_vs), .line_start(p_ls),
    .frame_start(p_fs), .frame_cnt(p_fc)
  );

  longint      k;        // enabled cycles since reset
  logic [15:0] off_s;    // frame_cnt offset introduced by the force on dut_s
  int          n_chk = 0;
  int          n_fail = 0;

  // Reference: after kk enabled cycles the outputs describe raster position kk-1
  function automatic obs_t model(input int ha, hfp, hsw, hbp, va, vfp, vsw, vbp,
                                 input bit hp, vp, input longint kk, input logic [15:0] off);
    obs_t o;
    int ht, vt, h, v;
    longint ft, p;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    ft = longint'(ht) * vt;
    if (kk == 0) begin
      o = '0;
      o.hs = ~hp;
      o.vs = ~vp;
      o.fc = off;
    end else begin
      p = (kk - 1) % ft;
      h = int'(p % ht);
      v = int'(p / ht);
      o.act = (h < ha) && (v < va);
      o.x = o.act ? 10'(h) : 10'd0;
      o.y = o.act ? 10'(v) : 10'd0;
      o.hs = (h >= ha + hfp && h < ha + hfp + hsw) ? hp : ~hp;
      o.vs = (v >= va + vfp && v < va + vfp + vsw) ? vp : ~vp;
      o.ls = (h == 0);
      o.fs = (h == 0) && (v == 0);
      o.fc = ((kk >= 2) ? 16'((kk - 2) / ft + 1) : 16'd0) + off;
    end
    return o;
  endfunction

  function automatic obs_t exp_b();
    return model(1024, 24, 136, 160, 768, 3, 6, 29, 1'b0, 1'b0, k, 16'd0);
  endfunction
  function automatic obs_t exp_s();
    return model(S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, 1'b0, 1'b0, k, off_s);
  endfunction
  function automatic obs_t exp_p();
    return model(S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, 1'b1, 1'b1, k, 16'd0);
  endfunction

  task automatic tick(input bit en, input bit r);
    pix_en = en;
    rst = r;
    @(posedge clk);
    if (r) begin
      k = 0;
      off_s = 16'd0;
    end else if (en) begin
      k++;
    end
    #1;
  endtask

  task automatic test_reset();
    obs_t e0, e1;
    e0 = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    e1 = {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tick(1'b0, 1'b1); tick(1'b1, 1'b1); tick(1'b1, 1'b1);
    n_chk++; if (ob_b !== e0) begin n_fail++; $display("FAIL reset_b got=%h exp=%h", ob_b, e0); end
    n_chk++; if (ob_s !== e0) begin n_fail++; $display("FAIL reset_s got=%h exp=%h", ob_s, e0); end
    n_chk++; if (ob_p !== e1) begin n_fail++; $display("FAIL reset_p got=%h exp=%h", ob_p, e1); end
    tick(1'b0, 1'b0);
    n_chk++; if (ob_b !== e0) begin n_fail++; $display("FAIL reset_hold got=%h exp=%h", ob_b, e0); end
  endtask

  task automatic test_first_pixel();
    obs_t e;
    e = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'd0};
    tick(1'b1, 1'b0);
    n_chk++; if (ob_b !== e) begin n_fail++; $display("FAIL first_pixel got=%h exp=%h", ob_b, e); end
    n_chk++; if ({p_hs, p_vs} !== 2'b00) begin n_fail++; $display("FAIL first_pol got=%b exp=00", {p_hs, p_vs}); end
    tick(1'b1, 1'b0);
    n_chk++; if (b_fc !== 16'd1) begin n_fail++; $display("FAIL first_fcnt got=%0d exp=1", b_fc); end
    n_chk++; if (b_fs !== 1'b0) begin n_fail++; $display("FAIL first_fs_drop got=%b exp=0", b_fs); end
  endtask

  task automatic test_line();
    int since, act_cnt, hs_cnt, hs_first, lines, wraps;
    bit seen, prev_act;
    logic [9:0] prev_x;
    seen = 0; lines = 0; wraps = 0; since = 0; act_cnt = 0; hs_cnt = 0; hs_first = -1;
    prev_act = 1'b0; prev_x = 10'd0;
    for (int i = 0; i < 3 * 1344; i++) begin
      tick(1'b1, 1'b0);
      n_chk++; if (ob_b !== exp_b()) begin n_fail++; $display("FAIL line_b k=%0d got=%h exp=%h", k, ob_b, exp_b()); end
      n_chk++; if (ob_s !== exp_s()) begin n_fail++; $display("FAIL line_s k=%0d got=%h exp=%h", k, ob_s, exp_s()); end
      if (prev_act && prev_x == 10'd1023) begin
        wraps++;
        n_chk++; if (b_x !== 10'd0) begin n_fail++; $display("FAIL x_after_1023 got=%0d exp=0", b_x); end
      end
      if (b_ls) begin
        if (seen) begin
          lines++;
          n_chk++; if (act_cnt != 1024) begin n_fail++; $display("FAIL active_len got=%0d exp=1024", act_cnt); end
          n_chk++; if (hs_cnt != 136) begin n_fail++; $display("FAIL hsync_len got=%0d exp=136", hs_cnt); end
          n_chk++; if (hs_first != 1048) begin n_fail++; $display("FAIL hsync_start got=%0d exp=1048", hs_first); end
          n_chk++; if (since != 1344) begin n_fail++; $display("FAIL line_period got=%0d exp=1344", since); end
        end
        seen = 1; since = 0; act_cnt = 0; hs_cnt = 0; hs_first = -1;
      end
      if (b_act) act_cnt++;
      if (!b_hs) begin
        if (hs_first < 0) hs_first = since;
        hs_cnt++;
      end
      since++;
      prev_act = b_act; prev_x = b_x;
    end
    n_chk++; if (lines < 2 || wraps < 2) begin n_fail++; $display("FAIL line_seen got=%0d/%0d exp>=2", lines, wraps); end
  endtask

  task automatic test_pix_en_pattern();
    obs_t prev_b;
    int en_since, periods;
    bit seen, en;
    prev_b = ob_b; en_since = 0; periods = 0; seen = 0;
    for (int i = 0; i < 4 * 1400; i++) begin
      en = (i % 4 == 0) || (i % 4 == 3);
      tick(en, 1'b0);
      n_chk++; if (ob_b !== exp_b()) begin n_fail++; $display("FAIL pat_b k=%0d got=%h exp=%h", k, ob_b, exp_b()); end
      n_chk++; if (ob_s !== exp_s()) begin n_fail++; $display("FAIL pat_s k=%0d got=%h exp=%h", k, ob_s, exp_s()); end
      if (!en) begin
        n_chk++; if (ob_b !== prev_b) begin n_fail++; $display("FAIL pat_hold got=%h exp=%h", ob_b, prev_b); end
      end else begin
        en_since++;
        if (b_ls) begin
          if (seen) begin
            periods++;
            n_chk++; if (en_since != 1344) begin n_fail++; $display("FAIL pat_period got=%0d exp=1344", en_since); end
          end
          seen = 1; en_since = 0;
        end
      end
      prev_b = ob_b;
    end
    n_chk++; if (periods < 1) begin n_fail++; $display("FAIL pat_seen got=%0d exp>=1", periods); end
  endtask

  task automatic test_frame();
    int since, vs_cnt, vs_first, blank, frames, ps_cnt;
    logic [9:0] ymax;
    bit seen;
    seen = 0; frames = 0; since = 0; vs_cnt = 0; vs_first = -1; blank = 0; ps_cnt = 0; ymax = 10'd0;
    for (int i = 0; i < 3 * 350 + 20; i++) begin
      tick(1'b1, 1'b0);
      n_chk++; if (ob_s !== exp_s()) begin n_fail++; $display("FAIL frame_s k=%0d got=%h exp=%h", k, ob_s, exp_s()); end
      n_chk++; if (ob_p !== exp_p()) begin n_fail++; $display("FAIL frame_p k=%0d got=%h exp=%h", k, ob_p, exp_p()); end
      n_chk++; if ({p_hs, p_vs} !== ~{s_hs, s_vs}) begin n_fail++; $display("FAIL pol_align got=%b exp=%b", {p_hs, p_vs}, ~{s_hs, s_vs}); end
      if (s_fs) begin
        if (seen) begin
          frames++;
          n_chk++; if (since != 350) begin n_fail++; $display("FAIL frame_period got=%0d exp=350", since); end
          n_chk++; if (vs_cnt != 50) begin n_fail++; $display("FAIL vsync_len got=%0d exp=50", vs_cnt); end
          n_chk++; if (vs_first != 225) begin n_fail++; $display("FAIL vsync_start got=%0d exp=225", vs_first); end
          n_chk++; if (ps_cnt != 50) begin n_fail++; $display("FAIL vsync_pos_len got=%0d exp=50", ps_cnt); end
          n_chk++; if (ymax != 10'd7) begin n_fail++; $display("FAIL ymax got=%0d exp=7", ymax); end
          n_chk++; if (blank != 6) begin n_fail++; $display("FAIL blank_lines got=%0d exp=6", blank); end
        end
        seen = 1; since = 0; vs_cnt = 0; vs_first = -1; blank = 0; ps_cnt = 0; ymax = 10'd0;
      end
      if (!s_vs) begin
        if (vs_first < 0) vs_first = since;
        vs_cnt++;
      end
      if (p_vs) ps_cnt++;
      if (s_y > ymax) ymax = s_y;
      if (s_ls && !s_act) begin
        blank++;
        n_chk++; if (s_y !== 10'd0) begin n_fail++; $display("FAIL blank_y got=%0d exp=0", s_y); end
      end
      since++;
    end
    n_chk++; if (frames < 2) begin n_fail++; $display("FAIL frame_seen got=%0d exp>=2", frames); end
  endtask

  task automatic test_random_en();
    bit en, r;
    for (int i = 0; i < 4000; i++) begin
      en = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 299) == 0);
      tick(en, r);
      n_chk++; if (ob_b !== exp_b()) begin n_fail++; $display("FAIL rand_b k=%0d got=%h exp=%h", k, ob_b, exp_b()); end
      n_chk++; if (ob_s !== exp_s()) begin n_fail++; $display("FAIL rand_s k=%0d got=%h exp=%h", k, ob_s, exp_s()); end
      n_chk++; if (ob_p !== exp_p()) begin n_fail++; $display("FAIL rand_p k=%0d got=%h exp=%h", k, ob_p, exp_p()); end
    end
  endtask

  task automatic test_mid_reset();
    obs_t e0, e1;
    e0 = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    e1 = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'd0};
    tick(1'b1, 1'b1);
    // two full frames, then land on h=10, v=5
    for (int i = 0; i < 700 + 136; i++) tick(1'b1, 1'b0);
    n_chk++; if ({s_x, s_y} !== {10'd10, 10'd5}) begin n_fail++; $display("FAIL mid_pos got=%0d,%0d exp=10,5", s_x, s_y); end
    n_chk++; if (s_fc !== 16'd3) begin n_fail++; $display("FAIL mid_fcnt got=%0d exp=3", s_fc); end
    tick(1'b1, 1'b1);
    n_chk++; if (ob_s !== e0) begin n_fail++; $display("FAIL mid_rst got=%h exp=%h", ob_s, e0); end
    tick(1'b1, 1'b0);
    n_chk++; if (ob_s !== e1) begin n_fail++; $display("FAIL mid_restart got=%h exp=%h", ob_s, e1); end
    tick(1'b1, 1'b0);
    n_chk++; if (s_fc !== 16'd1) begin n_fail++; $display("FAIL mid_fcnt1 got=%0d exp=1", s_fc); end
  endtask

  task automatic test_frame_cnt_wrap();
    obs_t e;
    bit found;
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      tick(1'b1, 1'b0);
      if ((k - 1) % 350 == 340) found = 1;
    end
    e = exp_s();
    force dut_s.frame_cnt_q = 16'hFFFF;
    release dut_s.frame_cnt_q;
    off_s = 16'hFFFF - e.fc;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick(1'b1, 1'b0);
      n_chk++; if (ob_s !== exp_s()) begin n_fail++; $display("FAIL wrap_s k=%0d got=%h exp=%h", k, ob_s, exp_s()); end
      if (s_fs) found = 1;
    end
    n_chk++; if (!found) begin n_fail++; $display("FAIL wrap_fs got=0 exp=1"); end
    n_chk++; if (s_fc !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_pre got=%0d exp=65535", s_fc); end
    tick(1'b1, 1'b0);
    n_chk++; if (s_fc !== 16'd0) begin n_fail++; $display("FAIL wrap_zero got=%0d exp=0", s_fc); end
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b0);
      n_chk++; if (ob_s !== exp_s()) begin n_fail++; $display("FAIL wrap_after k=%0d got=%h exp=%h", k, ob_s, exp_s()); end
    end
  endtask

  initial begin
    k = 0;
    off_s = 16'd0;
    test_reset();
    test_first_pixel();
    test_line();
    test_pix_en_pattern();
    test_frame();
    test_random_en();
    test_mid_reset();
    test_frame_cnt_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
